// File: rtl/alu_seq.sv
// Registered 8-function ALU with valid/ready handshakes on both sides.
// Divide and modulo share one multi-cycle restoring divider.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             dz
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_MOD  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_GT   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH:0]     r_rem;
  logic [CW-1:0]      r_cnt;
  logic               r_is_mod;
  logic [WIDTH:0]     r_out;
  logic               r_dz;
  logic               r_out_valid;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_is_divop;
  logic               w_start_div;
  logic [WIDTH:0]     w_shift;
  logic               w_fits;
  logic [WIDTH:0]     w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;

  // Result of every op that completes in one cycle, including div/mod by zero.
  function automatic logic [WIDTH:0] f_single(input logic [2:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH:0] res;
    res = '0;
    case (op)
      OP_PASS: res = {1'b0, x};
      OP_ADD:  res = {1'b0, x} + {1'b0, y};
      OP_SUB:  res = {1'b0, x} - {1'b0, y};
      OP_DIV:  res = {1'b0, {WIDTH{1'b1}}};
      OP_MOD:  res = {1'b0, x};
      OP_SHL:  res = {1'b0, x} << y;
      OP_SHR:  res = {1'b0, x >> y};
      OP_GT:   res = {{WIDTH{1'b0}}, (x > y)};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Handshake decode and one restoring-division step.
  always_comb begin
    w_in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    w_accept    = in_valid && w_in_ready;
    w_is_divop  = (sel == OP_DIV) || (sel == OP_MOD);
    w_start_div = w_is_divop && (b != {WIDTH{1'b0}});
    w_shift     = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    w_fits      = (w_shift >= {1'b0, r_b});
    if (w_fits) begin
      w_rem_next = w_shift - {1'b0, r_b};
    end else begin
      w_rem_next = w_shift;
    end
    w_quo_next  = {r_quo[WIDTH-2:0], w_fits};
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = w_start_div ? ST_DIV : ST_DONE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (r_cnt == {CW{1'b0}}) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_DIV;
        end
      end
      ST_DONE: begin
        if (w_accept) begin
          w_state_next = w_start_div ? ST_DIV : ST_DONE;
        end else if (out_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand capture, divider iteration and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b         <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_is_mod    <= 1'b0;
      r_out       <= '0;
      r_dz        <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_b      <= b;
      r_quo    <= a;
      r_rem    <= '0;
      r_cnt    <= CNT_LAST;
      r_is_mod <= (sel == OP_MOD);
      if (w_start_div) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out       <= f_single(sel, a, b);
        r_dz        <= w_is_divop;
        r_out_valid <= 1'b1;
      end
    end else if (r_state == ST_DIV) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt - CW'(1);
      // Last step: the remainder is below the divisor, so its MSB is always zero.
      if (r_cnt == {CW{1'b0}}) begin
        r_out       <= r_is_mod ? w_rem_next : {1'b0, w_quo_next};
        r_dz        <= 1'b0;
        r_out_valid <= 1'b1;
      end
    end else if ((r_state == ST_DONE) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign dz        = r_dz;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: WIDTH=4 and WIDTH=8 instances, directed vectors,
// expected results queued at issue and checked by per-instance monitors.
module tb_alu_seq;

  typedef struct {
    int o;
    int d;
  } exp_t;

  logic       clk;
  logic       rst;

  logic       in_valid4, u4_in_ready, u4_out_valid, out_ready4, u4_dz;
  logic [3:0] a4, b4;
  logic [2:0] sel4;
  logic [4:0] u4_out;

  logic       in_valid8, u8_in_ready, u8_out_valid, out_ready8, u8_dz;
  logic [7:0] a8, b8;
  logic [2:0] sel8;
  logic [8:0] u8_out;

  int   n_checks;
  int   n_fail;
  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;

  alu_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(u4_in_ready),
    .a(a4), .b(b4), .sel(sel4), .out_valid(u4_out_valid),
    .out_ready(out_ready4), .out(u4_out), .dz(u4_dz)
  );

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(u8_in_ready),
    .a(a8), .b(b8), .sel(sel8), .out_valid(u8_out_valid),
    .out_ready(out_ready8), .out(u8_out), .dz(u8_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Issue one op (called just after a rising edge), then measure latency.
  task automatic issue(input int dut, input int op, input int av, input int bv,
                       input int eo, input int ed, input int el);
    exp_t e;
    int   cyc;
    int   busy_bad;
    e.o = eo;
    e.d = ed;
    if (dut == 4) begin
      q4.push_back(e);
      in_valid4 = 1'b1; sel4 = op[2:0]; a4 = av[3:0]; b4 = bv[3:0];
    end else begin
      q8.push_back(e);
      in_valid8 = 1'b1; sel8 = op[2:0]; a8 = av[7:0]; b8 = bv[7:0];
    end
    @(negedge clk);
    check("in_ready_at_issue", (dut == 4) ? int'(u4_in_ready) : int'(u8_in_ready), 1);
    @(posedge clk);
    #1;
    // Garbage after the accept edge must not disturb the captured operands.
    if (dut == 4) begin
      in_valid4 = 1'b0; a4 = ~a4; b4 = ~b4; sel4 = ~sel4;
    end else begin
      in_valid8 = 1'b0; a8 = ~a8; b8 = ~b8; sel8 = ~sel8;
    end
    cyc = 1;
    busy_bad = 0;
    @(negedge clk);
    while (!((dut == 4) ? u4_out_valid : u8_out_valid) && cyc < 40) begin
      if ((dut == 4) ? u4_in_ready : u8_in_ready) busy_bad = 1;
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, el);
    if (el > 1) check("in_ready_low_while_busy", busy_bad, 0);
    @(posedge clk);
    #1;
  endtask

  // WIDTH=4 monitor: compare on every result handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && u4_out_valid && out_ready4) begin
        if (q4.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL w4_unexpected_result actual=%0d expected=none", u4_out);
        end else begin
          e4 = q4.pop_front();
          check("w4_out", int'(u4_out), e4.o);
          check("w4_dz", int'(u4_dz), e4.d);
        end
      end
    end
  end

  // WIDTH=8 monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && u8_out_valid && out_ready8) begin
        if (q8.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL w8_unexpected_result actual=%0d expected=none", u8_out);
        end else begin
          e8 = q8.pop_front();
          check("w8_out", int'(u8_out), e8.o);
          check("w8_dz", int'(u8_dz), e8.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    in_valid4 = 1'b0; a4 = 4'd0; b4 = 4'd0; sel4 = 3'd0; out_ready4 = 1'b1;
    in_valid8 = 1'b0; a8 = 8'd0; b8 = 8'd0; sel8 = 3'd0; out_ready8 = 1'b1;

    #12;
    check("reset_out_valid", int'(u4_out_valid), 0);
    check("reset_out", int'(u4_out), 0);
    check("reset_dz", int'(u4_dz), 0);
    check("reset_out_valid_w8", int'(u8_out_valid), 0);
    #10 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", int'(u4_in_ready), 1);
    check("idle_in_ready_w8", int'(u8_in_ready), 1);
    @(posedge clk);
    #1;

    // Single-cycle ops, WIDTH=4.
    issue(4, 1, 9, 8, 17, 0, 1);
    issue(4, 2, 3, 5, 30, 0, 1);
    issue(4, 5, 5, 2, 20, 0, 1);
    issue(4, 6, 9, 4, 0, 0, 1);
    issue(4, 7, 9, 4, 1, 0, 1);
    issue(4, 0, 7, 3, 7, 0, 1);
    issue(4, 5, 15, 5, 0, 0, 1);

    // Division, WIDTH=4.
    issue(4, 3, 13, 3, 4, 0, 5);
    issue(4, 4, 13, 3, 1, 0, 5);

    // Divide by zero, then a normal op clears dz.
    issue(4, 3, 6, 0, 15, 1, 1);
    issue(4, 4, 6, 0, 6, 1, 1);
    issue(4, 1, 1, 1, 2, 0, 1);

    // Backpressure: result held for 6 cycles.
    out_ready4 = 1'b0;
    issue(4, 1, 2, 3, 5, 0, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_out_stable", int'(u4_out), 5);
      check("bp_dz_stable", int'(u4_dz), 0);
      check("bp_in_ready_low", int'(u4_in_ready), 0);
      check("bp_out_valid_held", int'(u4_out_valid), 1);
    end
    @(posedge clk);
    #1;
    // Drain and accept on the same edge.
    e4.o = 13;
    e4.d = 0;
    q4.push_back(e4);
    out_ready4 = 1'b1;
    in_valid4 = 1'b1; sel4 = 3'd1; a4 = 4'd9; b4 = 4'd4;
    @(negedge clk);
    check("b2b_in_ready", int'(u4_in_ready), 1);
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    @(negedge clk);
    check("b2b_next_result_valid", int'(u4_out_valid), 1);
    @(posedge clk);
    #1;

    // Reset two cycles into a 13/3 division; out holds 13 beforehand.
    in_valid4 = 1'b1; sel4 = 3'd3; a4 = 4'd13; b4 = 4'd3;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", int'(u4_out_valid), 0);
    check("abort_out", int'(u4_out), 0);
    check("abort_dz", int'(u4_dz), 0);
    #3 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", int'(u4_in_ready), 1);
    check("abort_no_result", int'(u4_out_valid), 0);
    @(posedge clk);
    #1;
    issue(4, 4, 13, 3, 1, 0, 5);

    // Width scaling, WIDTH=8.
    issue(8, 1, 255, 255, 510, 0, 1);
    issue(8, 3, 200, 7, 28, 0, 9);
    issue(8, 4, 200, 7, 4, 0, 9);
    issue(8, 5, 1, 9, 0, 0, 1);
    issue(8, 2, 0, 1, 511, 0, 1);

    repeat (3) @(posedge clk);
    check("w4_queue_drained", q4.size(), 0);
    check("w8_queue_drained", q8.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-function combinational ALU.
- Same 3-bit opcode map, with these additions:
  - operand width set by `WIDTH`;
  - valid/ready handshakes on input and output;
  - multi-cycle restoring divider shared by divide and modulo;
  - divide-by-zero flag.
- Sits between an operand-issuing sequencer and a result consumer that may stall.

Parameters:
- `WIDTH`, 4, operand width in bits. Legal range is 2..32. The result is `WIDTH+1` bits.

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `in_valid`  input  1  operands and opcode are valid this cycle
- `in_ready`  output  1  block accepts operands this cycle
- `a`  input  `WIDTH`  operand A, unsigned
- `b`  input  `WIDTH`  operand B, unsigned
- `sel`  input  3  opcode: 0 pass A, 1 add, 2 sub, 3 div, 4 mod, 5 shl, 6 shr, 7 A>B
- `out_valid`  output  1  result valid
- `out_ready`  input  1  consumer takes the result this cycle
- `out`  output  `WIDTH+1`  result
- `dz`  output  1  divide-by-zero flag, qualified by `out_valid`

Behaviour:
- Reset (async, `rst`=1): state=IDLE. `out_valid`=0, `out`=0, `dz`=0, `in_ready`=1 once `rst` deasserts.
- A reset mid-operation aborts any division. The pending result is discarded.
- Accept: a transfer occurs on the rising edge when `in_valid`&&`in_ready`. `a`, `b` and `sel` are captured at that edge; later input changes have no effect.
- `in_ready` = (state==IDLE) || (state==DONE && `out_ready`). This allows back-to-back accept in the same cycle as result drain.
- States:
  - IDLE: on accept with `sel`∉{3,4}, or `sel`∈{3,4} with `b`==0 → DONE.
  - IDLE: on accept with `sel`∈{3,4} and `b`!=0 → DIV.
  - DIV: iteration counter runs `WIDTH`-1 down to 0; one restoring step per cycle. When the step at count 0 completes → DONE.
  - DONE: `out_valid`=1. On `out_ready`=1: if a new accept occurs in the same cycle, go to DONE or DIV as from IDLE; otherwise go to IDLE.
  - DONE with `out_ready`=0: `out` and `dz` hold stable.
- Latency from accept edge to `out_valid`:
  - Single-cycle ops and div/mod by zero: 1 cycle.
  - Div/mod with `b`!=0: `WIDTH`+1 cycles.
- Arithmetic (all unsigned, result `WIDTH+1` bits):
  - pass: {0,A}.
  - add: A+B including carry-out in the MSB.
  - sub: (A−B) mod 2^(`WIDTH`+1). A borrow shows as MSB=1, e.g. `WIDTH`=4: 3−5 = 5'b11110.
  - div: {0,quotient}.
  - mod: {0,remainder}.
  - shl: (A<<B) truncated to `WIDTH+1` bits. B ≥ `WIDTH+1` gives 0.
  - shr: A>>B. B ≥ `WIDTH` gives 0.
  - gt: 1 if A>B else 0, zero-extended.
- Divide by zero: div returns {0, all ones}; mod returns {0,A}. `dz`=1 for that result only; `dz`=0 for every other result.
- Divider: restoring algorithm with a remainder register of `WIDTH+1` bits and a quotient shift register of `WIDTH` bits. One quotient bit per cycle, MSB first.
- `in_ready`=0 throughout DIV. `out_valid`=0 throughout DIV.
- `out_ready` asserted while `out_valid`=0 has no effect.

Test Plan:
- Reset/idle: assert `rst` mid-division (`WIDTH`=4, 13/3, two cycles after accept) → `out_valid`=0, `out`=0 and `dz`=0 immediately (async). After release, `in_ready`=1 and the next op completes normally.
- Single-cycle ops, `WIDTH`=4, `out_ready`=1:
  - A=9,B=8 add → `out`=17 one cycle after accept.
  - A=3,B=5 sub → 30.
  - A=5,B=2 shl → 20.
  - A=9,B=4 shr → 0.
  - A=9,B=4 gt → 1.
  - A=7 pass → 7.
- Division, `WIDTH`=4: 13/3 → `out`=4, `dz`=0, `out_valid` exactly 5 cycles after accept. 13%3 → 1. `in_ready`=0 for cycles 1..4.
- Divide-by-zero, `WIDTH`=4: A=6,B=0 div → `out`=15, `dz`=1 after 1 cycle. mod → `out`=6, `dz`=1. The next op (add 1+1) returns 2 with `dz`=0.
- Backpressure: `out_ready`=0 for 6 cycles after a result → `out`/`dz` stable, `in_ready`=0. Raise `out_ready` together with `in_valid` → result drained and new operands accepted on the same edge. The new result appears on the next cycle.
- Width scaling, `WIDTH`=8: 255+255 → 510. 200/7 → 28 after 9 cycles. 200%7 → 4. 1<<9 → 0.
